// File: rtl/rhd_spi_slave.sv
// rhd_spi_slave: SPI command slave with 64x8 register file, 10-bit frame
// counter and a two-deep response pipeline shifted out on MISO.
// Ports: i_clk/i_rst system clock, sync active-high reset;
//   i_sclk/i_cs/i_mosi async SPI inputs (CS active-low, SCLK idle low);
//   o_miso serial response; o_cmd/o_cmd_valid last good command + pulse;
//   o_frame_err pulse on a frame that did not carry exactly 16 bits.
// Build option: RHD_SPI_SLAVE_DDR_EN interleaves A/B words on MISO
//   (A on falling SCLK, B on rising); without it only A is sent.
module rhd_spi_slave #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] CHIP_ID     = 8'd4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_sclk,
  input  logic        i_cs,
  input  logic        i_mosi,
  output logic        o_miso,
  output logic [15:0] o_cmd,
  output logic        o_cmd_valid,
  output logic        o_frame_err
);

`ifdef RHD_SPI_SLAVE_DDR_EN
  localparam int RW = 32;
`else
  localparam int RW = 16;
`endif

  typedef enum logic {
    ST_IDLE,
    ST_FRAME
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic sclk_prev_q, cs_prev_q;
  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, sclk_fall;
  logic cs_rise, cs_fall;

  logic [4:0]    cnt_q;
  logic [15:0]   sh_in_q;
  logic [9:0]    fcnt_q;
  logic [7:0]    regs_q [22];
  logic [RW-1:0] stg1_q, stg2_q;
  logic [15:0]   sho_a_q;
  logic          miso_q;
  logic [15:0]   cmd_q;
  logic          valid_q, err_q;

  logic load, rise_ev, fall_ev;
  logic done_ok, done_err;

  logic [1:0]    op;
  logic [5:0]    addr;
  logic [7:0]    wdata;
  logic [7:0]    rd_val;
  logic [15:0]   resp_a;
  logic [RW-1:0] resp;
  logic [15:0]   stg2_a;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign sclk_rise = ~sclk_prev_q & sclk_s;
  assign sclk_fall = sclk_prev_q & ~sclk_s;
  assign cs_rise   = ~cs_prev_q & cs_s;
  assign cs_fall   = cs_prev_q & ~cs_s;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], i_sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], i_cs};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], i_mosi};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
    end
  end

  // Frames only open on a CS fall seen after reset, so a frame that
  // was in progress at reset release is ignored to its end.
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // CS rise wins over an SCLK edge in the same cycle.
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    rise_ev  = 1'b0;
    fall_ev  = 1'b0;
    done_ok  = 1'b0;
    done_err = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d = ST_FRAME;
          load    = 1'b1;
        end
      end
      ST_FRAME: begin
        if (cs_rise) begin
          state_d  = ST_IDLE;
          done_ok  = (cnt_q == 5'd16);
          done_err = (cnt_q != 5'd16);
        end else begin
          rise_ev = sclk_rise;
          fall_ev = sclk_fall && (cnt_q != 5'd0);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign op    = sh_in_q[15:14];
  assign addr  = sh_in_q[13:8];
  assign wdata = sh_in_q[7:0];

  always_comb begin
    rd_val = 8'h00;
    unique case (1'b1)
      (addr < 6'd22):  rd_val = regs_q[addr[4:0]];
      (addr == 6'd40): rd_val = 8'h49;
      (addr == 6'd41): rd_val = 8'h4E;
      (addr == 6'd42): rd_val = 8'h54;
      (addr == 6'd43): rd_val = 8'h41;
      (addr == 6'd44): rd_val = 8'h4E;
      (addr == 6'd63): rd_val = CHIP_ID;
      default:         rd_val = 8'h00;
    endcase
  end

  always_comb begin
    resp_a = 16'h0000;
    case (op)
      2'b00:   resp_a = {addr, fcnt_q};
      2'b01:   resp_a = 16'h0000;
      2'b10:   resp_a = {8'hFF, wdata};
      default: resp_a = {8'h00, rd_val};
    endcase
  end

`ifdef RHD_SPI_SLAVE_DDR_EN
  logic [15:0] resp_b;
  logic [15:0] sho_b_q;

  assign resp_b = (op == 2'b00) ? ~resp_a : resp_a;
  assign resp   = {resp_a, resp_b};
`else
  assign resp   = resp_a;
`endif

  assign stg2_a = stg2_q[RW-1 -: 16];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q   <= '0;
      sh_in_q <= '0;
      fcnt_q  <= '0;
      stg1_q  <= '0;
      stg2_q  <= '0;
      sho_a_q <= '0;
      miso_q  <= 1'b0;
      cmd_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < 22; i++) regs_q[i] <= '0;
    end else begin
      valid_q <= done_ok;
      err_q   <= done_err;
      if (load) begin
        cnt_q   <= '0;
        sh_in_q <= '0;
        sho_a_q <= stg2_a;
        miso_q  <= stg2_a[15];
      end
      if (rise_ev) begin
        if (cnt_q != 5'd17) cnt_q <= cnt_q + 5'd1;
        sh_in_q <= {sh_in_q[14:0], mosi_s};
      end
      // Shifting zeros in makes MISO fall to 0 past bit 16.
      if (fall_ev) begin
        miso_q  <= sho_a_q[14];
        sho_a_q <= {sho_a_q[14:0], 1'b0};
      end
      if (done_ok) begin
        cmd_q  <= sh_in_q;
        stg1_q <= resp;
        stg2_q <= stg1_q;
        fcnt_q <= fcnt_q + 10'd1;
        if (op == 2'b10 && addr < 6'd22) regs_q[addr[4:0]] <= wdata;
      end
      if (done_ok || done_err) miso_q <= 1'b0;
`ifdef RHD_SPI_SLAVE_DDR_EN
      if (rise_ev) miso_q <= sho_b_q[15];
`endif
    end
  end

`ifdef RHD_SPI_SLAVE_DDR_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sho_b_q <= '0;
    end else if (load) begin
      sho_b_q <= stg2_q[15:0];
    end else if (rise_ev) begin
      sho_b_q <= {sho_b_q[14:0], 1'b0};
    end
  end
`endif

  assign o_miso      = miso_q;
  assign o_cmd       = cmd_q;
  assign o_cmd_valid = valid_q;
  assign o_frame_err = err_q;

endmodule

// File: tb/tb_rhd_spi_slave.sv
// tb_rhd_spi_slave: scoreboard bench for rhd_spi_slave.
// Model pushes responses per good frame; MISO words are popped/compared.
module tb_rhd_spi_slave;
  localparam int SYNC = 2;
  localparam int H    = 6;

  logic        clk = 1'b0;
  logic        rst, sclk, cs, mosi;
  logic        miso;
  logic [15:0] cmd;
  logic        cv, fe;

  always #5 clk = ~clk;

  rhd_spi_slave #(
    .SYNC_STAGES(SYNC),
    .CHIP_ID    (8'd4)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_sclk     (sclk),
    .i_cs       (cs),
    .i_mosi     (mosi),
    .o_miso     (miso),
    .o_cmd      (cmd),
    .o_cmd_valid(cv),
    .o_frame_err(fe)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int nvalid = 0;
  int nerr   = 0;

  always @(negedge clk) begin
    if (cv) nvalid++;
    if (fe) nerr++;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [7:0]  m_regs [22];
  logic [9:0]  m_fcnt;
  logic [31:0] exp_q [$];

  function automatic logic [7:0] m_read(input logic [5:0] a);
    if (a < 6'd22) return m_regs[a];
    case (a)
      6'd40:   return 8'h49;
      6'd41:   return 8'h4E;
      6'd42:   return 8'h54;
      6'd43:   return 8'h41;
      6'd44:   return 8'h4E;
      6'd63:   return 8'h04;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] model_resp(input logic [15:0] c);
    logic [15:0] a;
    case (c[15:14])
      2'b00: begin
        a = {c[13:8], m_fcnt};
        return {a, ~a};
      end
      2'b01:   return 32'h0;
      2'b10:   return {8'hFF, c[7:0], 8'hFF, c[7:0]};
      default: return {8'h00, m_read(c[13:8]), 8'h00, m_read(c[13:8])};
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 22; i++) m_regs[i] = 8'h00;
    m_fcnt = 10'd0;
    exp_q  = '{32'h0, 32'h0};
  endtask

  task automatic model_exec(input logic [15:0] c);
    logic [31:0] r;
    r = model_resp(c);
    if (c[15:14] == 2'b10 && c[13:8] < 6'd22) m_regs[c[13:8]] = c[7:0];
    m_fcnt = m_fcnt + 10'd1;
    void'(exp_q.pop_front());
    exp_q.push_back(r);
  endtask

  task automatic frame(input logic [15:0] c, input int nbits,
                       input bit chk, input int h);
    logic [15:0] ga, gb, eb;
    logic [31:0] e;
    logic        tail;
    int          v0, e0;
    e  = exp_q[0];
    v0 = nvalid;
    e0 = nerr;
    ga = '0;
    gb = '0;
    @(negedge clk);
    cs   = 1'b0;
    mosi = c[15];
    repeat (h) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (i < 16) ga[15-i] = miso;
      sclk = 1'b1;
      repeat (h) @(negedge clk);
      if (i < 16) gb[15-i] = miso;
      sclk = 1'b0;
      if (i < 15) mosi = c[14-i];
      else        mosi = 1'b0;
      repeat (h) @(negedge clk);
    end
    tail = miso;
    cs   = 1'b1;
    repeat (SYNC + 6) @(negedge clk);
`ifdef RHD_SPI_SLAVE_DDR_EN
    eb = e[15:0];
`else
    eb = e[31:16];
`endif
    if (nbits == 16) begin
      if (chk) begin
        check("miso_a", {16'h0, ga}, {16'h0, e[31:16]});
        check("miso_b", {16'h0, gb}, {16'h0, eb});
        check("miso_tail", {31'h0, tail}, 32'h0);
      end
      check("valid_pulses", nvalid - v0, 1);
      check("err_pulses", nerr - e0, 0);
      check("o_cmd", {16'h0, cmd}, {16'h0, c});
      model_exec(c);
    end else begin
      check("bad_err_pulses", nerr - e0, 1);
      check("bad_valid_pulses", nvalid - v0, 0);
    end
  endtask

  task automatic reset_mid_frame(input logic [15:0] c);
    logic quiet;
    int   v0, e0;
    @(negedge clk);
    cs   = 1'b0;
    mosi = c[15];
    repeat (H) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      sclk = 1'b1;
      repeat (H) @(negedge clk);
      sclk = 1'b0;
      mosi = c[14-i];
      repeat (H) @(negedge clk);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_miso", {31'h0, miso}, 32'h0);
    check("rst_cmd", {16'h0, cmd}, 32'h0);
    check("rst_valid", {31'h0, cv}, 32'h0);
    check("rst_err", {31'h0, fe}, 32'h0);
    rst = 1'b0;
    model_reset();
    v0    = nvalid;
    e0    = nerr;
    quiet = 1'b0;
    for (int i = 8; i < 16; i++) begin
      sclk = 1'b1;
      repeat (H) @(negedge clk);
      quiet |= miso;
      sclk = 1'b0;
      if (i < 15) mosi = c[14-i];
      else        mosi = 1'b0;
      repeat (H) @(negedge clk);
      quiet |= miso;
    end
    cs = 1'b1;
    repeat (SYNC + 6) @(negedge clk);
    check("rst_tail_miso", {31'h0, quiet}, 32'h0);
    check("rst_tail_valid", nvalid - v0, 0);
    check("rst_tail_err", nerr - e0, 0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst  = 1'b1;
    cs   = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    model_reset();
    repeat (4) @(negedge clk);
    check("reset_miso", {31'h0, miso}, 32'h0);
    check("reset_cmd", {16'h0, cmd}, 32'h0);
    check("reset_valid", {31'h0, cv}, 32'h0);
    check("reset_err", {31'h0, fe}, 32'h0);
    rst = 1'b0;
    repeat (SYNC + 4) @(negedge clk);

    repeat (3) frame(16'hFF00, 16, 1'b1, H);

    frame(16'h85A5, 16, 1'b1, H);
    frame(16'hC500, 16, 1'b1, H);
    frame(16'h0300, 16, 1'b1, H);
    frame(16'h2A00, 16, 1'b1, H);

    frame(16'hA812, 16, 1'b1, H);
    frame(16'hE800, 16, 1'b1, H);
    frame(16'hE900, 16, 1'b1, H);
    frame(16'h4000, 16, 1'b1, H);

    frame(16'hC500, 15, 1'b1, H);
    frame(16'hC500, 17, 1'b1, H);
    frame(16'h4000, 16, 1'b1, H);

    reset_mid_frame(16'h85A5);
    frame(16'hC500, 16, 1'b1, H);
    frame(16'h4000, 16, 1'b1, H);
    frame(16'h4000, 16, 1'b1, H);

    while (m_fcnt != 10'd1023) frame(16'h4000, 16, 1'b0, 1);
    frame(16'h0700, 16, 1'b1, H);
    frame(16'h0100, 16, 1'b1, H);
    frame(16'h4000, 16, 1'b1, H);
    frame(16'h4000, 16, 1'b1, H);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rhd_spi_slave.md
RHD_SPI_SLAVE -- requirements
Module: rhd_spi_slave

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning input synchronizer depth for i_sclk/i_cs/i_mosi (legal 2..4).
REQ-002 SHALL have parameter CHIP_ID, default 8'd4, meaning read-only value of register 63.
REQ-003 SHALL have port i_clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port i_sclk  input  1  SPI clock from master, asynchronous, idle low.
REQ-006 SHALL have port i_cs  input  1  chip select, active-low, asynchronous.
REQ-007 SHALL have port i_mosi  input  1  serial command, MSB first.
REQ-008 SHALL have port o_miso  output  1  serial response, DDR A/B interleave.
REQ-009 SHALL have port o_cmd  output  16  last complete command received.
REQ-010 SHALL have port o_cmd_valid  output  1  one-cycle pulse when o_cmd updates.
REQ-011 SHALL have port o_frame_err  output  1  one-cycle pulse on malformed frame.

Function
REQ-012 SHALL sync i_sclk, i_cs, i_mosi through SYNC_STAGES flops; detect edges on synchronized signals only.
REQ-013 SHALL define frame: synchronized CS falling edge to CS rising edge; SCLK edges while CS high ignored.
REQ-014 SHALL shift MOSI into 16-bit command register on each SCLK rising edge, MSB first; bit counter 0..17, saturating at 17.
REQ-015 SHALL on CS rise with count==16: latch o_cmd, pulse o_cmd_valid next cycle, execute command, advance response pipeline, increment frame counter (10-bit, wraps 1023->0).
REQ-016 SHALL on CS rise with count!=16: pulse o_frame_err, discard command, not advance pipeline or frame counter.
REQ-017 SHALL decode cmd[15:14]: 00 CONVERT ch=cmd[13:8]; 01 CALIBRATE/CLEAR; 10 WRITE reg=cmd[13:8] data=cmd[7:0]; 11 READ reg=cmd[13:8].
REQ-018 SHALL hold 64 x 8-bit register file; WRITE stores only to regs 0..21, others ignored; write visible to a READ in the immediately next frame.
REQ-019 SHALL return read-only values: regs 40..44 = 49h,4Eh,54h,41h,4Eh; reg 63 = CHIP_ID; other non-writable regs = 00h.
REQ-020 SHALL form response pair: CONVERT A={ch,frame_cnt}, B=~A; WRITE A=B={FFh,data}; READ A=B={00h,reg value}; CALIBRATE A=B=0000h.
REQ-021 SHALL use two-deep pipeline: response to command of frame N shifts out in frame N+2.
REQ-022 SHALL load shift-out pair at CS fall; drive A[15] immediately; after SCLK rising edge k drive B[15-k]; after SCLK falling edge k drive A[14-k].
REQ-023 SHALL drive o_miso = 0 while CS high and after bit 16 of a frame.
REQ-024 SHALL treat CS rise and SCLK edge detected in same cycle as CS rise first (edge ignored).

Reset
REQ-025 SHALL on i_rst clear synchronizers, bit counter, frame counter, writable registers, both pipeline stages (responses 0000h), o_cmd=0, o_cmd_valid=0, o_frame_err=0, o_miso=0.
REQ-026 SHALL, if reset releases while CS low, ignore the rest of that frame (no error pulse) until next CS fall.

Configuration
REQ-027 SHALL, with RHD_SPI_SLAVE_DDR_EN defined, implement DDR interleave per REQ-022.
REQ-028 SHALL, without RHD_SPI_SLAVE_DDR_EN, drive A word only: A[15] at CS fall, A[14-k] after falling edge k, no change on rising edges; B logic omitted.

Verification
REQ-029 SHALL cover: after reset, three frames READ reg 63 -> frame 3 returns A=B=0004h; frames 1-2 return 0000h.
REQ-030 SHALL cover: WRITE reg 5 = A5h, READ reg 5, two CONVERT -> frame 3 A=B=FFA5h, frame 4 A=B=00A5h.
REQ-031 SHALL cover: WRITE reg 40 = 12h then READ reg 40 (+2 frames) -> 0049h returned, reg unchanged.
REQ-032 SHALL cover: CONVERT ch 7 at frame_cnt 1023, then two frames -> A=1FFFh, B=E000h; next counter 0.
REQ-033 SHALL cover: 15-bit frame then 17-bit frame -> two o_frame_err pulses, no o_cmd_valid, pipeline unchanged.
REQ-034 SHALL cover: i_rst asserted mid-frame at bit 8 -> all outputs 0; remaining edges ignored; next full frame decodes normally.
